// File: rtl/rf_write_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
package rf_write_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      FORCE = 2'd2
   } rf_arb_state_t;

   localparam logic [4:0] X0_ADDR = 5'd0;

endpackage

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage has priority, and one
// long-latency result can be buffered. A buffered result that keeps losing
// arbitration is forced through by stalling writeback for one cycle.
// Optional macro RF_ARB_PERF_EN adds stall_cycles_o, a saturating count of
// cycles spent in FORCE.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        wb_valid_i,
   input  logic        wb_reg_write_i,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_result_i,
   input  logic        ll_valid_i,
   input  logic [4:0]  ll_rd_i,
   input  logic [31:0] ll_data_i,
   output logic        ll_ready_o,
   output logic        rf_we_o,
   output logic [4:0]  rf_waddr_o,
   output logic [31:0] rf_wdata_o,
   output logic        stall_w_o,
   output logic        ll_pending_o,
   output logic [4:0]  ll_pending_rd_o
`ifdef RF_ARB_PERF_EN
   ,
   output logic [31:0] stall_cycles_o
`endif
);

   localparam int              AGE_W    = $clog2(MAX_WAIT + 1);
   localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(MAX_WAIT - 1);

   rf_arb_state_t    state, state_next;
   logic [AGE_W-1:0] age, age_next;
   logic [4:0]       buf_rd;
   logic [31:0]      buf_data;
   logic             buf_load;
   logic             wb_req;
   logic             ll_accept;

   // Reset gates the combinational paths so every output reads 0 while it is held.
   assign wb_req     = ~reset_i & wb_valid_i & wb_reg_write_i & (wb_rd_i != X0_ADDR);
   assign ll_ready_o = ~reset_i & (state == IDLE);
   assign ll_accept  = ll_valid_i & ll_ready_o;

   // State, age and buffer flops; reset drops any buffered result unwritten.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state    <= IDLE;
         age      <= '0;
         buf_rd   <= '0;
         buf_data <= '0;
      end else begin
         state <= state_next;
         age   <= age_next;
         if (buf_load) begin
            buf_rd   <= ll_rd_i;
            buf_data <= ll_data_i;
         end
      end
   end

   // Next state: capture non-x0 results, count lost arbitrations, force when starved.
   always_comb begin
      state_next = state;
      age_next   = age;
      buf_load   = 1'b0;
      case (state)
         IDLE: begin
            if (ll_accept && (ll_rd_i != X0_ADDR)) begin
               state_next = PEND;
               age_next   = '0;
               buf_load   = 1'b1;
            end
         end
         PEND: begin
            if (!wb_req) begin
               state_next = IDLE;
            end else if (wb_rd_i == buf_rd) begin
               // Younger pipeline write to the same register supersedes the buffer.
               state_next = IDLE;
            end else if (age == AGE_LAST) begin
               state_next = FORCE;
            end else begin
               age_next = age + AGE_W'(1);
            end
         end
         FORCE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Write port and status decode; stall depends on state flops only.
   always_comb begin
      rf_we_o         = 1'b0;
      rf_waddr_o      = '0;
      rf_wdata_o      = '0;
      stall_w_o       = 1'b0;
      ll_pending_o    = 1'b0;
      ll_pending_rd_o = X0_ADDR;
      case (state)
         IDLE: begin
            if (wb_req) begin
               rf_we_o    = 1'b1;
               rf_waddr_o = wb_rd_i;
               rf_wdata_o = wb_result_i;
            end
         end
         PEND: begin
            ll_pending_o    = 1'b1;
            ll_pending_rd_o = buf_rd;
            rf_we_o         = 1'b1;
            if (wb_req) begin
               rf_waddr_o = wb_rd_i;
               rf_wdata_o = wb_result_i;
            end else begin
               rf_waddr_o = buf_rd;
               rf_wdata_o = buf_data;
            end
         end
         FORCE: begin
            ll_pending_o    = 1'b1;
            ll_pending_rd_o = buf_rd;
            stall_w_o       = 1'b1;
            rf_we_o         = 1'b1;
            rf_waddr_o      = buf_rd;
            rf_wdata_o      = buf_data;
         end
         default: begin
            rf_we_o = 1'b0;
         end
      endcase
   end

`ifdef RF_ARB_PERF_EN
   // Saturating count of forced-write stall cycles.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stall_cycles_o <= '0;
      end else if ((state == FORCE) && (stall_cycles_o != 32'hFFFF_FFFF)) begin
         stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: a per-cycle vector table checked through a
// scoreboard queue, plus hand sequences for reset mid-PEND and MAX_WAIT=1.
module tb_rf_write_arbiter;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        wb_valid_i, wb_reg_write_i, ll_valid_i;
   logic [4:0]  wb_rd_i, ll_rd_i;
   logic [31:0] wb_result_i, ll_data_i;

   logic        ll_ready, rf_we, stall_w, ll_pending;
   logic [4:0]  rf_waddr, ll_pending_rd;
   logic [31:0] rf_wdata;

   logic        ll_ready_m1, rf_we_m1, stall_w_m1, ll_pending_m1;
   logic [4:0]  rf_waddr_m1, ll_pending_rd_m1;
   logic [31:0] rf_wdata_m1;
`ifdef RF_ARB_PERF_EN
   logic [31:0] stall_cycles, stall_cycles_m1;
`endif

   always #5 clk_i = ~clk_i;

   rf_write_arbiter #(.MAX_WAIT(4)) dut (
      .clk_i(clk_i), .reset_i(reset_i),
      .wb_valid_i(wb_valid_i), .wb_reg_write_i(wb_reg_write_i),
      .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
      .ll_valid_i(ll_valid_i), .ll_rd_i(ll_rd_i), .ll_data_i(ll_data_i),
      .ll_ready_o(ll_ready), .rf_we_o(rf_we), .rf_waddr_o(rf_waddr),
      .rf_wdata_o(rf_wdata), .stall_w_o(stall_w),
      .ll_pending_o(ll_pending), .ll_pending_rd_o(ll_pending_rd)
`ifdef RF_ARB_PERF_EN
      , .stall_cycles_o(stall_cycles)
`endif
   );

   rf_write_arbiter #(.MAX_WAIT(1)) dut_m1 (
      .clk_i(clk_i), .reset_i(reset_i),
      .wb_valid_i(wb_valid_i), .wb_reg_write_i(wb_reg_write_i),
      .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
      .ll_valid_i(ll_valid_i), .ll_rd_i(ll_rd_i), .ll_data_i(ll_data_i),
      .ll_ready_o(ll_ready_m1), .rf_we_o(rf_we_m1), .rf_waddr_o(rf_waddr_m1),
      .rf_wdata_o(rf_wdata_m1), .stall_w_o(stall_w_m1),
      .ll_pending_o(ll_pending_m1), .ll_pending_rd_o(ll_pending_rd_m1)
`ifdef RF_ARB_PERF_EN
      , .stall_cycles_o(stall_cycles_m1)
`endif
   );

   typedef struct {
      logic        wv, wr;
      logic [4:0]  wrd;
      logic [31:0] wd;
      logic        lv;
      logic [4:0]  lrd;
      logic [31:0] ld;
      logic        we;
      logic [4:0]  a;
      logic [31:0] d;
      logic        st, rdy, pend;
      logic [4:0]  prd;
      logic [31:0] cnt;
   } vec_t;

   localparam int NV = 23;
   vec_t tbl [NV];
   vec_t exp_q [$];
   int   total = 0;
   int   bad   = 0;

   function automatic vec_t mk(input logic wv, input logic wr, input logic [4:0] wrd,
                               input logic [31:0] wd, input logic lv, input logic [4:0] lrd,
                               input logic [31:0] ld, input logic we, input logic [4:0] a,
                               input logic [31:0] d, input logic st, input logic rdy,
                               input logic pend, input logic [4:0] prd, input logic [31:0] cnt);
      vec_t v;
      v.wv = wv; v.wr = wr; v.wrd = wrd; v.wd = wd;
      v.lv = lv; v.lrd = lrd; v.ld = ld;
      v.we = we; v.a = a; v.d = d; v.st = st; v.rdy = rdy;
      v.pend = pend; v.prd = prd; v.cnt = cnt;
      return v;
   endfunction

   function automatic vec_t idle_row(input logic [31:0] cnt);
      return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, cnt);
   endfunction

   task automatic check(input string name, input int idx, input logic [31:0] act,
                        input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, want);
      end
   endtask

   task automatic set_in(input vec_t v);
      wb_valid_i     = v.wv;
      wb_reg_write_i = v.wr;
      wb_rd_i        = v.wrd;
      wb_result_i    = v.wd;
      ll_valid_i     = v.lv;
      ll_rd_i        = v.lrd;
      ll_data_i      = v.ld;
   endtask

   initial begin
      vec_t e;

      // Pipeline only, x0 filtering, non-writing instruction
      tbl[0]  = idle_row(0);
      tbl[1]  = mk(1, 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 1, 0, 0, 0);
      tbl[2]  = mk(1, 1, 0, 32'h1111, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[3]  = mk(1, 0, 6, 32'h2222, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      // Idle drain
      tbl[4]  = mk(0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 1, 7, 0);
      tbl[6]  = idle_row(0);
      // LL result to x0 is discarded
      tbl[7]  = mk(0, 0, 0, 0, 1, 0, 32'h55, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[8]  = idle_row(0);
      // Starvation, MAX_WAIT=4
      tbl[9]  = mk(0, 0, 0, 0, 1, 9, 32'hCAFE, 0, 0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++)
         tbl[10+k] = mk(1, 1, 3, 32'h100 + k, 0, 0, 0, 1, 3, 32'h100 + k, 0, 0, 1, 9, 0);
      tbl[14] = mk(1, 1, 3, 32'h104, 0, 0, 0, 1, 9, 32'hCAFE, 1, 0, 1, 9, 0);
      tbl[15] = mk(1, 1, 3, 32'h104, 0, 0, 0, 1, 3, 32'h104, 0, 1, 0, 0, 1);
      // Same-rd override; LL valid while busy is not accepted
      tbl[16] = mk(0, 0, 0, 0, 1, 9, 32'hBEEF, 0, 0, 0, 0, 1, 0, 0, 1);
      tbl[17] = mk(1, 1, 9, 32'hAA, 1, 12, 32'hCC, 1, 9, 32'hAA, 0, 0, 1, 9, 1);
      tbl[18] = idle_row(1);
      tbl[19] = idle_row(1);
      // Simultaneous pipeline write and LL accept, then drain
      tbl[20] = mk(1, 1, 2, 32'h22, 1, 8, 32'h88, 1, 2, 32'h22, 0, 1, 0, 0, 1);
      tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 32'h88, 0, 0, 1, 8, 1);
      tbl[22] = idle_row(1);

      // Reset: outputs forced to 0 even with a writeback request present
      reset_i = 1'b1;
      set_in(mk(1, 1, 5, 32'h77, 1, 6, 32'h66, 0, 0, 0, 0, 0, 0, 0, 0));
      #2;
      check("rst_we", 0, rf_we, 0);
      check("rst_addr", 0, rf_waddr, 0);
      check("rst_data", 0, rf_wdata, 0);
      check("rst_ready", 0, ll_ready, 0);
      check("rst_stall", 0, stall_w, 0);
      check("rst_pend", 0, ll_pending, 0);
      set_in(idle_row(0));
      @(posedge clk_i);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      @(negedge clk_i);
      check("post_rst_ready", 0, ll_ready, 1);
      check("post_rst_we", 0, rf_we, 0);

      // Table-driven vectors through the scoreboard
      for (int i = 0; i < NV; i++) begin
         @(posedge clk_i);
         #1;
         set_in(tbl[i]);
         exp_q.push_back(tbl[i]);
         @(negedge clk_i);
         e = exp_q.pop_front();
         check("we", i, rf_we, e.we);
         check("waddr", i, rf_waddr, e.a);
         check("wdata", i, rf_wdata, e.d);
         check("stall", i, stall_w, e.st);
         check("ready", i, ll_ready, e.rdy);
         check("pend", i, ll_pending, e.pend);
         check("pend_rd", i, ll_pending_rd, e.prd);
`ifdef RF_ARB_PERF_EN
         check("stall_cnt", i, stall_cycles, e.cnt);
`endif
      end

      // Reset while the buffer holds rd=4
      @(posedge clk_i);
      #1 set_in(mk(0, 0, 0, 0, 1, 4, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      check("mid_accept_ready", 0, ll_ready, 1);
      @(posedge clk_i);
      #1 set_in(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      check("mid_pend", 0, ll_pending, 1);
      check("mid_pend_rd", 0, ll_pending_rd, 4);
      check("mid_waddr", 0, rf_waddr, 3);
      #2 reset_i = 1'b1;
      #1;
      check("mid_rst_we", 0, rf_we, 0);
      check("mid_rst_waddr", 0, rf_waddr, 0);
      check("mid_rst_wdata", 0, rf_wdata, 0);
      check("mid_rst_pend", 0, ll_pending, 0);
      check("mid_rst_pend_rd", 0, ll_pending_rd, 0);
      check("mid_rst_ready", 0, ll_ready, 0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      set_in(idle_row(0));
      for (int c = 0; c < 2; c++) begin
         @(negedge clk_i);
         check("post_mid_we", c, rf_we, 0);
         check("post_mid_ready", c, ll_ready, 1);
         check("post_mid_pend", c, ll_pending, 0);
         @(posedge clk_i);
         #1;
      end

      // MAX_WAIT=1: first lost cycle leads straight to FORCE
      set_in(mk(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      check("m1_ready", 0, ll_ready_m1, 1);
      @(posedge clk_i);
      #1 set_in(mk(1, 1, 3, 32'h33, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      check("m1_lost_stall", 0, stall_w_m1, 0);
      check("m1_lost_waddr", 0, rf_waddr_m1, 3);
      check("m1_lost_pend", 0, ll_pending_m1, 1);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("m1_force_stall", 0, stall_w_m1, 1);
      check("m1_force_waddr", 0, rf_waddr_m1, 9);
      check("m1_force_wdata", 0, rf_wdata_m1, 32'h99);
      check("m4_no_stall", 0, stall_w, 0);
      check("m4_waddr", 0, rf_waddr, 3);
      @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("m1_after_stall", 0, stall_w_m1, 0);
      check("m1_after_waddr", 0, rf_waddr_m1, 3);
      check("m1_after_pend", 0, ll_pending_m1, 0);
      set_in(idle_row(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Shares the single register-file write port between the in-order writeback stage and an out-of-band long-latency result source (multi-cycle multiply/divide). Sits directly after the writeback pipeline register and drives the register file write port. Holds one long-latency result in a buffer and gives the pipeline priority. When the buffered result has waited `MAX_WAIT` cycles, the block stalls the writeback stage for one cycle to force the buffered write through.

## Interface
- `MAX_WAIT`, 4, number of consecutive cycles the pipeline may win arbitration over a buffered result (legal range ≥ 1).
- `clk_i`  in  1  clock.
- `reset_i`  in  1  reset; asynchronous, active-high.
- `wb_valid_i`  in  1  writeback stage holds a valid instruction.
- `wb_reg_write_i`  in  1  writeback instruction writes a register.
- `wb_rd_i`  in  5  writeback destination register.
- `wb_result_i`  in  32  writeback result.
- `ll_valid_i`  in  1  long-latency unit presents a result.
- `ll_rd_i`  in  5  long-latency destination register.
- `ll_data_i`  in  32  long-latency result.
- `ll_ready_o`  out  1  buffer can accept a result this cycle.
- `rf_we_o`  out  1  register file write enable.
- `rf_waddr_o`  out  5  register file write address.
- `rf_wdata_o`  out  32  register file write data.
- `stall_w_o`  out  1  stall request to the writeback pipeline register.
- `ll_pending_o`  out  1  buffer holds an unwritten result (for the hazard unit).
- `ll_pending_rd_o`  out  5  destination of the buffered result.

## Operation
- `wb_req = wb_valid_i & wb_reg_write_i & (wb_rd_i != 0)`. Writes to x0 are never issued.
- Long-latency accept: `ll_valid_i & ll_ready_o`. Data with `ll_rd_i == 0` is accepted and discarded.
- `ll_ready_o = (state == IDLE)`. The buffer is single-entry with no same-cycle refill.
- FSM state register, buffer (`buf_rd`, `buf_data`) and age counter (width `$clog2(MAX_WAIT+1)`) are all flops.
- IDLE:
  - `rf_*` follows `wb_req`: `rf_we_o = wb_req`, with address and data from the `wb_*` inputs.
  - Non-x0 accept → PEND with age = 0.
- PEND:
  - If `wb_req` is low: write the buffer, then → IDLE.
  - If `wb_req` is high and `wb_rd_i == buf_rd`: write the pipeline value, drop the buffer, then → IDLE. The pipeline instruction is younger by construction, so its value wins.
  - Otherwise: write the pipeline value and increment age. When age reaches `MAX_WAIT-1`, → FORCE.
- FORCE:
  - `stall_w_o = 1`. The buffer is written and `wb_*` is ignored.
  - → IDLE.
  - The stalled writeback instruction stays in its register and is written in the following cycle. It is not retired during the stall.
- `ll_pending_o = (state != IDLE)`. `ll_pending_rd_o = buf_rd`, or 0 when in IDLE.
- `rf_waddr_o`/`rf_wdata_o` are 0 whenever `rf_we_o` is 0.

## Timing
- Reset (asynchronous, takes effect immediately): state = IDLE, age = 0, buffer = 0.
  - While `reset_i` is high, all outputs are 0, including `ll_ready_o`.
  - After reset: `ll_ready_o = 1`, everything else 0 until a request arrives.
- The `rf_*` write port is combinational from the `wb_*` inputs plus flops, so a pipeline write reaches the port with zero latency.
- `stall_w_o` is decoded from the state flops only, with no input-to-output path.
- Buffered result latency: a result accepted in cycle N is written in N+1 at the earliest. The worst case is N+1+`MAX_WAIT`, when the last of those cycles is FORCE.
- With `MAX_WAIT = 1`, the first lost arbitration cycle moves the FSM to FORCE in the next cycle.
- A reset asserted while in PEND or FORCE drops the buffered result with no write.

## Configuration
- `RF_ARB_PERF_EN` defined: adds output `stall_cycles_o` (32-bit).
  - Counts cycles spent in FORCE.
  - Saturates at 0xFFFFFFFF.
  - Reset value 0.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package: the state enum `rf_arb_state_t` (IDLE, PEND, FORCE) and the `X0_ADDR` constant.
- No sub-modules. The buffer and the FSM are one module. The optional counter is inline under the macro.

## Test plan
- Pipeline only: `wb_req` with rd=5, data 0xDEADBEEF → `rf_we_o=1`, `rf_waddr_o=5`, `rf_wdata_o=0xDEADBEEF` in the same cycle; `stall_w_o` stays 0.
- Idle drain: LL accept rd=7, data 0x1234 in cycle 0 with no `wb_req` → cycle 1 writes rd=7 with 0x1234; `ll_ready_o` is 0 in cycle 1 and 1 in cycle 2.
- Starvation with `MAX_WAIT=4`: LL accept rd=9 in cycle 0, then continuous `wb_req` to rd=3 → pipeline writes in cycles 1–4, cycle 5 has `stall_w_o=1` and writes rd=9, cycle 6 writes the held rd=3; `stall_cycles_o` becomes 1.
- Same-rd override: buffer holds rd=9; `wb_req` rd=9, data 0xAA → write 0xAA, `ll_pending_o` drops next cycle, and no later write to rd=9 occurs.
- x0 filtering: `wb_req` with rd=0 → `rf_we_o=0`; LL accept with rd=0 → FSM stays in IDLE and `ll_pending_o=0`.
- Reset mid-PEND: assert `reset_i` while the buffer holds rd=4 → outputs go to 0 immediately; after release there is no write to rd=4 and `ll_ready_o=1`.
